pattern_frame_writer: RTL and testbench

// Parametrised test-pattern source for the RGB LED panel pixel RAM. Sweeps every pixel address, computes a

---
 rtl/panel_pkg.sv | 32 +++
 rtl/pattern_frame_writer_if.sv | 25 ++
 rtl/pattern_frame_writer_color.sv | 46 ++++
 rtl/pattern_frame_writer.sv | 120 ++++++++++++
 tb/tb_pattern_frame_writer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/panel_pkg.sv
// Shared constants for the LED panel: pattern modes, FSM states and the {R,G,B} colour-word layout.
// panel_driver unpacks pixel words with the same chan_lsb offsets.
package panel_pkg;

  localparam logic [1:0] MODE_SOLID   = 2'd0;
  localparam logic [1:0] MODE_HGRAD   = 2'd1;
  localparam logic [1:0] MODE_VBARS   = 2'd2;
  localparam logic [1:0] MODE_CHECKER = 2'd3;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE,
    ST_FRAME_END
  } pfw_state_e;

  // Channels are packed MSB-first; unused low bits of the RAM word stay zero.
  function automatic int chan_lsb(input int data_w, input int color_bits, input int ch);
    return data_w - (ch + 1) * color_bits;
  endfunction

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_COLOR_BITS = 2;
  localparam int R_LSB = chan_lsb(DEF_DATA_W, DEF_COLOR_BITS, CH_R);
  localparam int G_LSB = chan_lsb(DEF_DATA_W, DEF_COLOR_BITS, CH_G);
  localparam int B_LSB = chan_lsb(DEF_DATA_W, DEF_COLOR_BITS, CH_B);

endpackage

// File: rtl/pattern_frame_writer_if.sv
// Control inputs and pixel-RAM write port of the pattern writer.
// master = pattern_frame_writer, slave = the block that enables it and owns the RAM.
interface pattern_frame_writer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              i_enable;
  logic [1:0]        i_mode;
  logic [ADDR_W-1:0] o_w_addr;
  logic [DATA_W-1:0] o_w_data;
  logic              o_w_enable;
  logic              o_front_buf;
  logic              o_frame_done;
  logic [7:0]        o_frame_count;

  modport master (
    input  i_enable, i_mode,
    output o_w_addr, o_w_data, o_w_enable, o_front_buf, o_frame_done, o_frame_count
  );

  modport slave (
    output i_enable, i_mode,
    input  o_w_addr, o_w_data, o_w_enable, o_front_buf, o_frame_done, o_frame_count
  );
endinterface

// File: rtl/pattern_frame_writer_color.sv
// Combinational colour generator: {mode, phase, row parity, column} -> packed {R,G,B} RAM word.
// Phase is always 0..2, so channel indices never exceed B.
module pattern_color
  import panel_pkg::*;
#(
  parameter int COLS_W     = 6,
  parameter int COLOR_BITS = 2,
  parameter int DATA_W     = 16
) (
  input  logic [1:0]        mode_i,
  input  logic [1:0]        phase_i,
  input  logic              row_lsb_i,
  input  logic [COLS_W-1:0] col_i,
  output logic [DATA_W-1:0] data_o
);
  localparam logic [COLOR_BITS-1:0] CMAX = {COLOR_BITS{1'b1}};

  logic [COLOR_BITS+COLS_W-1:0] col_ext;
  logic [COLOR_BITS-1:0]        grad;
  logic [1:0]                   next_ch;
  logic [1:0]                   bar_ch;
  logic [2:0][COLOR_BITS-1:0]   ch;

  // Zero-padding keeps the gradient slice legal on panels narrower than the colour depth.
  assign col_ext = {col_i, {COLOR_BITS{1'b0}}};
  assign grad    = col_ext[COLOR_BITS+COLS_W-1 -: COLOR_BITS];
  assign next_ch = (phase_i == 2'd2) ? 2'd0 : phase_i + 2'd1;
  assign bar_ch  = 2'((int'(col_i >> 3) + int'(phase_i)) % 3);

  always_comb begin
    ch = '0;
    case (mode_i)
      MODE_SOLID: begin
        ch[phase_i] = CMAX;
        ch[next_ch] = CMAX >> 1;
      end
      MODE_HGRAD: ch[phase_i] = grad;
      MODE_VBARS: ch[bar_ch]  = CMAX;
      default:    if (row_lsb_i ^ col_i[0] ^ phase_i[0]) ch = {3{CMAX}};
    endcase
    data_o = '0;
    for (int c = 0; c < 3; c++) begin
      data_o[chan_lsb(DATA_W, COLOR_BITS, c) +: COLOR_BITS] = ch[c];
    end
  end
endmodule

// File: rtl/pattern_frame_writer.sv
// Test-pattern source sweeping every pixel of the panel RAM, one registered write per PIX_DIV+1 clocks.
// i_enable low parks the FSM in WAIT on the next pixel; mode changes take effect only at frame boundaries.
module pattern_frame_writer
  import panel_pkg::*;
#(
  parameter int COLS       = 64,
  parameter int ROWS       = 64,
  parameter int COLOR_BITS = 2,
  parameter int DATA_W     = 16,
  parameter int PIX_DIV    = 1,
  parameter int DOUBLE_BUF = 0
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  pattern_frame_writer_if.master bus
);
  localparam int COLS_W = $clog2(COLS);
  localparam int ROWS_W = $clog2(ROWS);
  localparam int PIX_W  = COLS_W + ROWS_W;
  localparam int ADDR_W = PIX_W + DOUBLE_BUF;
  localparam int DIV_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(PIX_DIV - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(COLS * ROWS - 1);

  pfw_state_e        state_q;
  logic [PIX_W-1:0]  idx_q;
  logic [1:0]        phase_q;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              w_en_q;
  logic              front_q;
  logic              done_q;
  logic [7:0]        count_q;

  pattern_color #(
    .COLS_W    (COLS_W),
    .COLOR_BITS(COLOR_BITS),
    .DATA_W    (DATA_W)
  ) u_color (
    .mode_i   (mode_q),
    .phase_i  (phase_q),
    .row_lsb_i(idx_q[COLS_W]),
    .col_i    (idx_q[COLS_W-1:0]),
    .data_o   (w_data_d)
  );

  // The back buffer is always the one panel_driver is not scanning.
  always_comb begin
    w_addr_d = '0;
    w_addr_d[PIX_W-1:0] = idx_q;
    if (DOUBLE_BUF != 0) w_addr_d[ADDR_W-1] = ~front_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      phase_q  <= '0;
      div_q    <= '0;
      mode_q   <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_en_q   <= 1'b0;
      front_q  <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      w_en_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.i_enable) begin
            mode_q  <= bus.i_mode;
            div_q   <= DIV_INIT;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (div_q != '0) begin
            div_q <= div_q - DIV_W'(1);
          end else if (bus.i_enable) begin
            w_en_q   <= 1'b1;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            state_q  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (idx_q == LAST_PIX) begin
            idx_q   <= '0;
            done_q  <= 1'b1;
            count_q <= count_q + 8'd1;
            phase_q <= (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
            if (DOUBLE_BUF != 0) front_q <= ~front_q;
            state_q <= ST_FRAME_END;
          end else begin
            idx_q   <= idx_q + PIX_W'(1);
            div_q   <= DIV_INIT;
            state_q <= ST_WAIT;
          end
        end
        ST_FRAME_END: begin
          mode_q  <= bus.i_mode;
          div_q   <= DIV_INIT;
          state_q <= bus.i_enable ? ST_WAIT : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_w_addr      = w_addr_q;
  assign bus.o_w_data      = w_data_q;
  assign bus.o_w_enable    = w_en_q;
  assign bus.o_front_buf   = front_q;
  assign bus.o_frame_done  = done_q;
  assign bus.o_frame_count = count_q;
endmodule

// File: tb/tb_pattern_frame_writer.sv
// Bench for pattern_frame_writer on a 4x4 panel: single-buffer instance driven frame-by-frame from a
// table, plus a double-buffered instance; writes are scored against a reference colour model.
module tb_pattern_frame_writer;
  logic clk;
  logic rst;

  pattern_frame_writer_if #(.ADDR_W(4), .DATA_W(16)) bus ();
  pattern_frame_writer_if #(.ADDR_W(5), .DATA_W(16)) bus_db ();

  pattern_frame_writer #(
    .COLS(4), .ROWS(4), .COLOR_BITS(2), .DATA_W(16), .PIX_DIV(1), .DOUBLE_BUF(0)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  pattern_frame_writer #(
    .COLS(4), .ROWS(4), .COLOR_BITS(2), .DATA_W(16), .PIX_DIV(1), .DOUBLE_BUF(1)
  ) dut_db (
    .i_clk(clk), .i_reset(rst), .bus(bus_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    logic        front;
  } exp_t;

  typedef struct {
    logic [1:0]  mode_next;
    int          chg_at;
    int          pause_at;
    int          pause_len;
    logic [15:0] exp_w0;
    logic [15:0] exp_w15;
    logic [7:0]  exp_cnt;
  } frame_vec_t;

  exp_t        exp_q[$];
  exp_t        db_q[$];
  frame_vec_t  tbl[8];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  int          pix_cnt = 0;
  int          strobe_cnt = 0;
  int          frames_done = 0;
  int          db_done = 0;
  logic [3:0]  last_addr = '0;
  logic [15:0] w0 = '0;
  logic [15:0] w15 = '0;
  logic [7:0]  m_count = '0;
  logic        gap_chk = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_color(input logic [1:0] mode, input int ph, input int idx);
    int row;
    int col;
    logic [1:0] ch[3];
    row = idx / 4;
    col = idx % 4;
    ch[0] = 2'd0; ch[1] = 2'd0; ch[2] = 2'd0;
    case (mode)
      2'd0: begin ch[ph] = 2'd3; ch[(ph + 1) % 3] = 2'd1; end
      2'd1: ch[ph] = 2'(col);
      2'd2: ch[((col / 8) + ph) % 3] = 2'd3;
      default: if (((row ^ col ^ ph) & 1) == 1) begin ch[0] = 2'd3; ch[1] = 2'd3; ch[2] = 2'd3; end
    endcase
    return {ch[0], ch[1], ch[2], 10'b0};
  endfunction

  task automatic push_main(input logic [1:0] mode, input int ph);
    for (int p = 0; p < 16; p++) exp_q.push_back('{addr: 5'(p), data: exp_color(mode, ph, p), front: 1'b0});
  endtask

  task automatic push_db(input logic back);
    for (int p = 0; p < 16; p++) db_q.push_back('{addr: {back, 4'(p)}, data: 16'h0, front: ~back});
  endtask

  task automatic wait_pix(input int n);
    int k = 0;
    while (pix_cnt < n && k < 500) begin @(posedge clk); #2; k++; end
    check("wait_pixels", 32'(pix_cnt >= n), 32'd1);
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames_done < n && k < 500) begin @(posedge clk); #2; k++; end
    check("wait_frame_done", 32'(frames_done >= n), 32'd1);
  endtask

  task automatic wait_db(input int n);
    int k = 0;
    while (db_done < n && k < 500) begin @(posedge clk); #2; k++; end
    check("wait_db_frame_done", 32'(db_done >= n), 32'd1);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard for the single-buffer instance.
  always @(negedge clk) begin : mon_main
    exp_t e;
    if (!rst) begin
      if (bus.o_w_enable) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_empty: unexpected write addr %0d, expected no write", bus.o_w_addr);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.o_w_addr), 32'(e.addr));
          check("wr_data", 32'(bus.o_w_data), 32'(e.data));
        end
        if (gap_chk && pix_cnt > 0) check("strobe_gap", 32'(cyc - last_cyc), 32'd2);
        if (bus.o_w_addr == 4'd0)  w0  = bus.o_w_data;
        if (bus.o_w_addr == 4'd15) w15 = bus.o_w_data;
        last_cyc = cyc;
        last_addr = bus.o_w_addr;
        pix_cnt++;
        strobe_cnt++;
      end
      if (bus.o_frame_done) begin
        check("done_latency", 32'(cyc - last_cyc), 32'd1);
        check("done_after_last", 32'(last_addr), 32'd15);
        check("frame_pixels", 32'(pix_cnt), 32'd16);
        m_count = m_count + 8'd1;
        check("frame_count", 32'(bus.o_frame_count), 32'(m_count));
        pix_cnt = 0;
        frames_done++;
      end
    end
  end

  always @(negedge clk) begin : mon_db
    exp_t e;
    if (!rst) begin
      if (bus_db.o_w_enable) begin
        if (db_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL db_sb_empty: unexpected write addr %0d, expected no write", bus_db.o_w_addr);
        end else begin
          e = db_q.pop_front();
          check("db_addr", 32'(bus_db.o_w_addr), 32'(e.addr));
          check("db_front", 32'(bus_db.o_front_buf), 32'(e.front));
        end
      end
      if (bus_db.o_frame_done) db_done++;
    end
  end

  initial begin
    logic [1:0] fmode;
    int s;
    tbl[0] = '{2'd0, 0, 0, 0,  16'hD000, 16'hD000, 8'd1};
    tbl[1] = '{2'd0, 0, 0, 0,  16'h3400, 16'h3400, 8'd2};
    tbl[2] = '{2'd0, 0, 0, 0,  16'h4C00, 16'h4C00, 8'd3};
    tbl[3] = '{2'd3, 5, 8, 20, 16'hD000, 16'hD000, 8'd4};
    tbl[4] = '{2'd3, 0, 0, 0,  16'hFC00, 16'hFC00, 8'd5};
    tbl[5] = '{2'd2, 0, 0, 0,  16'h0000, 16'h0000, 8'd6};
    tbl[6] = '{2'd1, 0, 0, 0,  16'hC000, 16'hC000, 8'd7};
    tbl[7] = '{2'd1, 0, 0, 0,  16'h0000, 16'h3000, 8'd8};

    rst = 1'b1;
    bus.i_enable = 1'b0;    bus.i_mode = 2'd0;
    bus_db.i_enable = 1'b0; bus_db.i_mode = 2'd0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_w_enable", 32'(bus.o_w_enable), 32'd0);
    check("rst_w_addr", 32'(bus.o_w_addr), 32'd0);
    check("rst_w_data", 32'(bus.o_w_data), 32'd0);
    check("rst_frame_done", 32'(bus.o_frame_done), 32'd0);
    check("rst_frame_count", 32'(bus.o_frame_count), 32'd0);
    check("rst_front_buf", 32'(bus_db.o_front_buf), 32'd0);
    rst = 1'b0;

    fmode = 2'd0;
    for (int k = 0; k < 8; k++) begin
      push_main(fmode, k % 3);
      fmode = tbl[k].mode_next;
    end

    @(posedge clk); #2;
    bus.i_enable = 1'b1;
    gap_chk = 1'b1;
    @(posedge clk); #2;
    check("first_wait_no_strobe", 32'(bus.o_w_enable), 32'd0);
    @(posedge clk); #2;
    check("first_strobe", 32'(bus.o_w_enable), 32'd1);
    check("first_addr", 32'(bus.o_w_addr), 32'd0);

    for (int i = 0; i < 8; i++) begin
      gap_chk = (tbl[i].pause_at == 0);
      wait_pix(tbl[i].chg_at);
      bus.i_mode = tbl[i].mode_next;
      if (tbl[i].pause_at > 0) begin
        wait_pix(tbl[i].pause_at);
        bus.i_enable = 1'b0;
        s = strobe_cnt;
        repeat (tbl[i].pause_len) @(posedge clk);
        #2;
        check("pause_no_strobe", 32'(strobe_cnt), 32'(s));
        bus.i_enable = 1'b1;
        wait_pix(tbl[i].pause_at + 1);
        check("resume_addr", 32'(last_addr), 32'(tbl[i].pause_at));
      end
      wait_frames(i + 1);
      check("frame_w0", 32'(w0), 32'(tbl[i].exp_w0));
      check("frame_w15", 32'(w15), 32'(tbl[i].exp_w15));
      check("tbl_frame_count", 32'(bus.o_frame_count), 32'(tbl[i].exp_cnt));
    end
    bus.i_enable = 1'b0;

    // Double-buffered instance: back buffer flips after every frame.
    push_db(1'b1); push_db(1'b0); push_db(1'b1);
    bus_db.i_enable = 1'b1;
    wait_db(1);
    check("db_front_after_f0", 32'(bus_db.o_front_buf), 32'd1);
    wait_db(2);
    check("db_front_after_f1", 32'(bus_db.o_front_buf), 32'd0);
    wait_db(3);
    check("db_front_after_f2", 32'(bus_db.o_front_buf), 32'd1);
    bus_db.i_enable = 1'b0;

    // Resume main instance (frame 8: mode 1, phase 2), then reset asynchronously in a WAIT cycle.
    push_main(2'd1, 2);
    bus.i_enable = 1'b1;
    wait_pix(3);
    #1 rst = 1'b1;
    #1;
    check("arst_w_enable", 32'(bus.o_w_enable), 32'd0);
    check("arst_frame_count", 32'(bus.o_frame_count), 32'd0);
    check("arst_frame_done", 32'(bus.o_frame_done), 32'd0);
    check("arst_db_front_buf", 32'(bus_db.o_front_buf), 32'd0);
    check("arst_db_frame_count", 32'(bus_db.o_frame_count), 32'd0);
    exp_q.delete();
    pix_cnt = 0;
    m_count = 8'd0;
    gap_chk = 1'b0;
    bus.i_mode = 2'd0;
    push_main(2'd0, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    wait_pix(2);
    check("restart_last_addr", 32'(last_addr), 32'd1);
    check("restart_w0", 32'(w0), 32'hD000);
    bus.i_enable = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
